led_code_sequencer: RTL and testbench

- Upstream stage for the team's 3-to-8 one-hot decoder.
- Produces the 3-bit select code that drives the decoder inputs: code[2] to in1, code[1] to in2, code[0] to in3.
- Advances the code on a programmable time base in up, down, ping-pong or hold mode, so the decoded 8-bit output forms an LED chaser.
- Also supports manual single-stepping while paused.

---
 rtl/led_code_sequencer.sv | 126 ++++++++++++
 tb/tb_led_code_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/led_code_sequencer.sv
// Divider-paced 3-bit select-code generator for the 3-to-8 LED decoder. It supports up, down,
// ping-pong and hold modes, plus manual stepping. Optional macro: LED_SEQ_STEP_EDGE_EN.
module led_code_sequencer #(
    parameter int unsigned CNT_MAX = 24_999_999,
    localparam int unsigned CNT_W  = (CNT_MAX == 0) ? 1 : $clog2(64'(CNT_MAX) + 64'd1)
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       step,
    output logic [2:0] code,
    output logic       tick,
    output logic       wrap
);

    typedef enum logic [1:0] {
        ModeUp   = 2'b00,
        ModeDown = 2'b01,
        ModePing = 2'b10,
        ModeHold = 2'b11
    } mode_e;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(CNT_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       code_q, code_d;
    dir_e             pp_dir_q, pp_dir_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             step_req;
    logic             advance;
    logic [2:0]       pp_next;

`ifdef LED_SEQ_STEP_EDGE_EN
    // Two synchroniser flops plus one history flop for rising-edge detection.
    logic [2:0] step_sync_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            step_sync_q <= 3'b000;
        end else begin
            step_sync_q <= {step_sync_q[1:0], step};
        end
    end

    assign step_req = step_sync_q[1] & ~step_sync_q[2];
`else
    assign step_req = step;
`endif

    assign advance = (en && (cnt_q == CntMax)) || (!en && step_req);

    always_comb begin
        cnt_d    = cnt_q;
        code_d   = code_q;
        pp_dir_d = pp_dir_q;
        tick_d   = 1'b0;
        wrap_d   = 1'b0;
        pp_next  = code_q;

        if (!en || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (pp_dir_q == DirUp) begin
            pp_next = (code_q == 3'd7) ? 3'd6 : code_q + 3'd1;
        end else begin
            pp_next = (code_q == 3'd0) ? 3'd1 : code_q - 3'd1;
        end

        if (advance) begin
            tick_d = 1'b1;
            unique case (mode_e'(mode))
                ModeUp: begin
                    code_d = code_q + 3'd1;
                    wrap_d = (code_q == 3'd7);
                end
                ModeDown: begin
                    code_d = code_q - 3'd1;
                    wrap_d = (code_q == 3'd0);
                end
                ModePing: begin
                    code_d = pp_next;
                    wrap_d = (pp_next == 3'd7) || (pp_next == 3'd0);
                    if (pp_next == 3'd7) pp_dir_d = DirDown;
                    if (pp_next == 3'd0) pp_dir_d = DirUp;
                end
                ModeHold: begin
                    code_d = code_q;
                end
                default: begin
                    code_d = code_q;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q    <= '0;
            code_q   <= 3'd0;
            pp_dir_q <= DirUp;
            tick_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            pp_dir_q <= pp_dir_d;
            tick_q   <= tick_d;
            wrap_q   <= wrap_d;
        end
    end

    assign code = code_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_led_code_sequencer.sv
// Directed, table-driven bench for led_code_sequencer with CNT_MAX=3 (one advance per 4 cycles).
module tb_led_code_sequencer;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       en      = 1'b0;
    logic [1:0] mode    = 2'b00;
    logic       step    = 1'b0;
    logic [2:0] code;
    logic       tick;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    led_code_sequencer #(.CNT_MAX(3)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (en),
        .mode    (mode),
        .step    (step),
        .code    (code),
        .tick    (tick),
        .wrap    (wrap)
    );

    always #5 sys_clk = ~sys_clk;

    // Inputs are held for ncyc cycles; tick/wrap must stay low until the last cycle,
    // where code/tick/wrap are compared against the record.
    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic       step;
        int         ncyc;
        logic [2:0] code;
        logic       tick;
        logic       wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic e, input logic [1:0] m,
                                input logic s, input int n, input logic [2:0] c,
                                input logic t, input logic w);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.step = s; v.ncyc = n;
        v.code = c; v.tick = t; v.wrap = w;
        vecs.push_back(v);
    endfunction

    task automatic cycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check3(input string name, input logic [2:0] c, input logic t,
                          input logic w);
        checks++;
        if (code !== c || tick !== t || wrap !== w) begin
            errors++;
            $display("FAIL %s: got code=%0d tick=%b wrap=%b, want code=%0d tick=%b wrap=%b",
                     name, code, tick, wrap, c, t, w);
        end
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if (tick !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL %s: got tick=%b wrap=%b between advances, want 0 0",
                     name, tick, wrap);
        end
    endtask

    initial begin
        logic [2:0] c0;
        logic [2:0] pc;

        // Reset, then free-run up through a full wrap.
        add(1, 0, 2'b00, 0, 1, 3'd0, 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 1, 2'b00, 0, 4, 3'(k % 8), 1, k == 8);
        // Down from 0 wraps to 7.
        add(0, 1, 2'b01, 0, 4, 3'd7, 1, 1);
        add(0, 1, 2'b01, 0, 4, 3'd6, 1, 0);
        add(0, 1, 2'b01, 0, 4, 3'd5, 1, 0);
        // Reset, then ping-pong 1..7..0..1.
        add(1, 1, 2'b10, 0, 1, 3'd0, 0, 0);
        for (int k = 1; k <= 15; k++) begin
            pc = (k <= 7) ? 3'(k) : ((k <= 14) ? 3'(14 - k) : 3'(k - 14));
            add(0, 1, 2'b10, 0, 4, pc, 1, (pc == 3'd7) || (pc == 3'd0));
        end
        // Up to 5, hold there, then resume up.
        for (int k = 2; k <= 5; k++) add(0, 1, 2'b00, 0, 4, 3'(k), 1, 0);
        add(0, 1, 2'b11, 0, 4, 3'd5, 1, 0);
        add(0, 1, 2'b11, 0, 4, 3'd5, 1, 0);
        add(0, 1, 2'b00, 0, 4, 3'd6, 1, 0);
        // Pause; manual steps (level-sampled build only).
        add(0, 0, 2'b00, 0, 2, 3'd6, 0, 0);
`ifndef LED_SEQ_STEP_EDGE_EN
        add(0, 0, 2'b00, 1, 1, 3'd7, 1, 0);
        add(0, 0, 2'b00, 0, 1, 3'd7, 0, 0);
        add(0, 0, 2'b00, 1, 1, 3'd0, 1, 1);
        add(0, 0, 2'b00, 0, 1, 3'd0, 0, 0);
        add(0, 0, 2'b00, 1, 1, 3'd1, 1, 0);
        add(0, 0, 2'b00, 0, 1, 3'd1, 0, 0);
        c0 = 3'd1;
`else
        c0 = 3'd6;
`endif
        // step ignored while en=1; en falling at cnt==CNT_MAX suppresses the advance.
        add(0, 1, 2'b00, 1, 3, c0, 0, 0);
        add(0, 0, 2'b00, 0, 1, c0, 0, 0);
        add(0, 1, 2'b00, 0, 4, c0 + 3'd1, 1, 0);

        foreach (vecs[i]) begin
            sys_rst = vecs[i].rst;
            en      = vecs[i].en;
            mode    = vecs[i].mode;
            step    = vecs[i].step;
            for (int j = 0; j < vecs[i].ncyc - 1; j++) begin
                cycle();
                check_quiet($sformatf("vec%0d_gap%0d", i, j));
            end
            cycle();
            check3($sformatf("vec%0d", i), vecs[i].code, vecs[i].tick, vecs[i].wrap);
        end

        // Reset mid-run at cnt=2, code=6, ping-pong heading down.
        sys_rst = 1; en = 1; mode = 2'b10; step = 0;
        cycle();
        check3("pp_rst", 3'd0, 0, 0);
        sys_rst = 0;
        repeat (32) cycle();
        check3("pp_at6_down", 3'd6, 1, 0);
        repeat (2) cycle();
        sys_rst = 1;
        cycle();
        check3("midrun_rst", 3'd0, 0, 0);
        sys_rst = 0;
        repeat (4) cycle();
        check3("post_rst_adv1", 3'd1, 1, 0);
        repeat (4) cycle();
        check3("post_rst_dir_up", 3'd2, 1, 0);

`ifdef LED_SEQ_STEP_EDGE_EN
        begin
            int ntick;
            int at;
            en = 0; mode = 2'b00; step = 0;
            repeat (4) cycle();
            c0 = code;
            ntick = 0;
            at = -1;
            step = 1;
            for (int c = 1; c <= 20; c++) begin
                cycle();
                if (tick === 1'b1) begin
                    ntick++;
                    if (at < 0) at = c;
                end
            end
            step = 0;
            checks++;
            if (ntick != 1 || at != 3 || code !== c0 + 3'd1) begin
                errors++;
                $display("FAIL edge_step: got ticks=%0d first_at=%0d code=%0d, want 1 3 %0d",
                         ntick, at, code, c0 + 3'd1);
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
